// File: rtl/data_mem_arbiter.sv
// Shares one data memory between the MEM stage and a DMA port: a DMA access takes one GRANT cycle plus a DONE cycle.
// The pipeline wins conflicts until the DMA has lost STARVE_LIMIT times, after which it is stalled for one cycle.
module data_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        PipeMemReadIn,
  input  logic        PipeMemWriteIn,
  input  logic [31:0] PipeAddrIn,
  input  logic [31:0] PipeWriteDataIn,
  input  logic        PipeByteIn,
  input  logic        PipeHalfIn,
  output logic [31:0] PipeReadDataOut,
  input  logic        DmaReqIn,
  input  logic        DmaWriteIn,
  input  logic [31:0] DmaAddrIn,
  input  logic [31:0] DmaWriteDataIn,
  input  logic        DmaByteIn,
  input  logic        DmaHalfIn,
  output logic        DmaGrantOut,
  output logic        DmaDoneOut,
  output logic [31:0] DmaReadDataOut,
  output logic        StallOut,
  output logic [31:0] MemAddrOut,
  output logic [31:0] MemWriteDataOut,
  output logic        MemWriteOut,
  output logic        MemReadOut,
  output logic        MemByteOut,
  output logic        MemHalfOut,
  input  logic [31:0] MemReadDataIn
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       pipe_acc;
  logic       dma_owns;

  assign pipe_acc = PipeMemReadIn | PipeMemWriteIn;
  assign dma_owns = (state == GRANT);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // The count only moves while the DMA is actually losing a conflict, so it saturates at LIMIT.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    unique case (state)
      IDLE: begin
        if (DmaReqIn) begin
          if (!pipe_acc || (starve_cnt >= LIMIT)) begin
            state_nxt  = GRANT;
            starve_nxt = 4'd0;
          end else begin
            starve_nxt = starve_cnt + 4'd1;
          end
        end
      end
      GRANT:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DmaReadDataOut <= 32'd0;
    end else if (dma_owns && !DmaWriteIn) begin
      DmaReadDataOut <= MemReadDataIn;
    end
  end

  assign DmaGrantOut     = dma_owns;
  assign DmaDoneOut      = (state == DONE);
  assign StallOut        = dma_owns & pipe_acc;
  assign PipeReadDataOut = MemReadDataIn;

  // Strobes are gated by reset directly so an access aborted mid-GRANT never reaches the memory.
  assign MemAddrOut      = dma_owns ? DmaAddrIn      : PipeAddrIn;
  assign MemWriteDataOut = dma_owns ? DmaWriteDataIn : PipeWriteDataIn;
  assign MemByteOut      = dma_owns ? DmaByteIn      : PipeByteIn;
  assign MemHalfOut      = dma_owns ? DmaHalfIn      : PipeHalfIn;
  assign MemWriteOut     = Reset_n & (dma_owns ? DmaWriteIn  : PipeMemWriteIn);
  assign MemReadOut      = Reset_n & (dma_owns ? ~DmaWriteIn : PipeMemReadIn);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Two arbiters (STARVE_LIMIT 4 and 0) share stimulus; each has its own word memory and a reference model.
module tb_data_mem_arbiter;

  localparam int LIM0 = 4;
  localparam int LIM1 = 0;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        pr, pw, pb, ph, req, dw, db, dh;
  logic [31:0] pa, pwd, da, dwd;

  logic [31:0] prd [2];
  logic [31:0] rdo [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd [2];
  logic [31:0] mrdata [2];
  logic        gnt [2];
  logic        done [2];
  logic        stall [2];
  logic        mwr [2];
  logic        mrd [2];
  logic        mbyte [2];
  logic        mhalf [2];

  logic [31:0] mem [2][64];
  logic        init_done = 1'b0;

  // reference model
  int          m_phase [2];
  int          m_lost [2];
  int          lim [2];
  logic [31:0] m_rd [2];
  logic [31:0] m_mem [2][64];

  // snapshots of the last checked cycle
  logic        s_gnt [2];
  logic        s_done [2];
  logic        s_stall [2];
  logic        s_mbyte [2];
  logic        s_mhalf [2];

  function automatic logic [31:0] init_val(input int k, input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hA5A5_0000 + 32'(i) + 32'(k * 256);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!init_done) begin
        for (int i = 0; i < 64; i++) mem[k][i] <= init_val(k, i);
      end else if (mwr[k]) begin
        mem[k][maddr[k][7:2]] <= mwd[k];
      end
    end
  end

  assign mrdata[0] = mem[0][maddr[0][7:2]];
  assign mrdata[1] = mem[1][maddr[1][7:2]];

  data_mem_arbiter #(.STARVE_LIMIT(LIM0)) u_dut0 (
    .Clk(clk), .Reset_n(rst_n),
    .PipeMemReadIn(pr), .PipeMemWriteIn(pw), .PipeAddrIn(pa), .PipeWriteDataIn(pwd),
    .PipeByteIn(pb), .PipeHalfIn(ph), .PipeReadDataOut(prd[0]),
    .DmaReqIn(req), .DmaWriteIn(dw), .DmaAddrIn(da), .DmaWriteDataIn(dwd),
    .DmaByteIn(db), .DmaHalfIn(dh), .DmaGrantOut(gnt[0]), .DmaDoneOut(done[0]),
    .DmaReadDataOut(rdo[0]), .StallOut(stall[0]),
    .MemAddrOut(maddr[0]), .MemWriteDataOut(mwd[0]), .MemWriteOut(mwr[0]), .MemReadOut(mrd[0]),
    .MemByteOut(mbyte[0]), .MemHalfOut(mhalf[0]), .MemReadDataIn(mrdata[0])
  );

  data_mem_arbiter #(.STARVE_LIMIT(LIM1)) u_dut1 (
    .Clk(clk), .Reset_n(rst_n),
    .PipeMemReadIn(pr), .PipeMemWriteIn(pw), .PipeAddrIn(pa), .PipeWriteDataIn(pwd),
    .PipeByteIn(pb), .PipeHalfIn(ph), .PipeReadDataOut(prd[1]),
    .DmaReqIn(req), .DmaWriteIn(dw), .DmaAddrIn(da), .DmaWriteDataIn(dwd),
    .DmaByteIn(db), .DmaHalfIn(dh), .DmaGrantOut(gnt[1]), .DmaDoneOut(done[1]),
    .DmaReadDataOut(rdo[1]), .StallOut(stall[1]),
    .MemAddrOut(maddr[1]), .MemWriteDataOut(mwd[1]), .MemWriteOut(mwr[1]), .MemReadOut(mrd[1]),
    .MemByteOut(mbyte[1]), .MemHalfOut(mhalf[1]), .MemReadDataIn(mrdata[1])
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0;
      m_lost[k]  = 0;
      m_rd[k]    = 32'd0;
    end
  endtask

  // A DMA transfer is: wait for a win, one cycle owning the memory, one cycle reporting completion.
  task automatic model_step();
    if (!rst_n) return;
    for (int k = 0; k < 2; k++) begin
      if (m_phase[k] == 1) begin
        if (dw) m_mem[k][da[7:2]] = dwd;
        else    m_rd[k] = m_mem[k][da[7:2]];
        m_phase[k] = 2;
      end else begin
        if (pw) m_mem[k][pa[7:2]] = pwd;
        if (m_phase[k] == 2) begin
          m_phase[k] = 0;
        end else if (req) begin
          if (!(pr || pw) || m_lost[k] >= lim[k]) begin
            m_phase[k] = 1;
            m_lost[k]  = 0;
          end else begin
            m_lost[k]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic        own;
    logic [31:0] e_addr;
    for (int k = 0; k < 2; k++) begin
      own    = rst_n && (m_phase[k] == 1);
      e_addr = own ? da : pa;
      chk1("grant",     k, gnt[k],   own);
      chk1("done",      k, done[k],  rst_n && (m_phase[k] == 2));
      chk1("stall",     k, stall[k], own && (pr || pw));
      chk ("mem_addr",  k, maddr[k], e_addr);
      chk ("mem_wdata", k, mwd[k],   own ? dwd : pwd);
      chk1("mem_write", k, mwr[k],   rst_n && (own ? dw : pw));
      chk1("mem_read",  k, mrd[k],   rst_n && (own ? !dw : pr));
      chk1("mem_byte",  k, mbyte[k], own ? db : pb);
      chk1("mem_half",  k, mhalf[k], own ? dh : ph);
      chk ("pipe_rdata", k, prd[k],  m_mem[k][e_addr[7:2]]);
      chk ("dma_rdata", k, rdo[k],   m_rd[k]);
      s_gnt[k]   = gnt[k];
      s_done[k]  = done[k];
      s_stall[k] = stall[k];
      s_mbyte[k] = mbyte[k];
      s_mhalf[k] = mhalf[k];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int g0, g1, st1, n_done, n_gnt;
    lim[0] = LIM0;
    lim[1] = LIM1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) m_mem[k][i] = init_val(k, i);
    {pr, pw, pb, ph, req, dw, db, dh} = '0;
    pa = 32'd0; pwd = 32'd0; da = 32'd0; dwd = 32'd0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 init_done = 1'b1;

    // reset state, with pipeline strobes that must be blocked
    tick();
    pr = 1'b1; pw = 1'b1; pa = 32'h8;
    tick();
    pr = 1'b0; pw = 1'b0;
    rst_n = 1'b1;
    tick();

    // uncontended DMA read of 0x10
    req = 1'b1; dw = 1'b0; da = 32'h10;
    tick();
    chk1("rd_c0_grant", 0, s_gnt[0], 1'b0);
    tick();
    chk1("rd_c1_grant", 0, s_gnt[0], 1'b1);
    chk1("rd_c1_stall", 0, s_stall[0], 1'b0);
    tick();
    chk1("rd_c2_done", 0, s_done[0], 1'b1);
    req = 1'b0;
    chk("rd_data", 0, rdo[0], 32'hDEADBEEF);
    chk("rd_data", 1, rdo[1], 32'hDEADBEEF);
    tick();

    // contended DMA write; limit 4 loses four times, limit 0 wins at once
    pr = 1'b1; pa = 32'h40;
    req = 1'b1; dw = 1'b1; da = 32'h20; dwd = 32'h12345678;
    g0 = -1; g1 = -1; st1 = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (s_gnt[1] && g1 < 0) begin g1 = c; st1 = int'(s_stall[1]); end
      if (s_gnt[0] && g0 < 0) g0 = c;
      if (s_done[0]) break;
    end
    req = 1'b0;
    chk("starve_grant_cycle", 0, 32'(g0), 32'(LIM0 + 1));
    chk("zero_limit_grant_cycle", 1, 32'(g1), 32'd1);
    chk("zero_limit_stall", 1, 32'(st1), 32'd1);
    pr = 1'b0;
    tick();
    tick();
    tick();
    chk("wr_mem", 0, mem[0][8], 32'h12345678);
    chk("wr_mem", 1, mem[1][8], 32'h12345678);

    // byte DMA write alongside a halfword-sized idle pipeline
    ph = 1'b1;
    req = 1'b1; dw = 1'b1; db = 1'b1; da = 32'h30; dwd = $urandom;
    tick();
    chk1("byte_idle_mbyte", 0, s_mbyte[0], 1'b0);
    chk1("byte_idle_mhalf", 0, s_mhalf[0], 1'b1);
    tick();
    chk1("byte_grant_mbyte", 0, s_mbyte[0], 1'b1);
    chk1("byte_grant_mhalf", 0, s_mhalf[0], 1'b0);
    tick();
    chk1("byte_done_mbyte", 0, s_mbyte[0], 1'b0);
    req = 1'b0; db = 1'b0; ph = 1'b0;
    tick();

    // reset in the middle of a DMA write
    req = 1'b1; dw = 1'b1; da = 32'h34; dwd = 32'hCAFEF00D;
    tick();
    chk1("abort_in_grant", 0, gnt[0], 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk1("abort_mem_write", 0, mwr[0], 1'b0);
    chk1("abort_grant", 0, gnt[0], 1'b0);
    n_done = 0;
    tick();
    n_done += int'(s_done[0]);
    req = 1'b0;
    rst_n = 1'b1;
    tick();
    n_done += int'(s_done[0]);
    tick();
    n_done += int'(s_done[0]);
    chk("abort_no_done", 0, 32'(n_done), 32'd0);
    chk("abort_mem_kept", 0, mem[0][13], init_val(0, 13));

    // back-to-back transfers with the request held high
    req = 1'b1; dw = 1'b0; da = 32'h44;
    n_done = 0; n_gnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_done += int'(s_done[0]);
      n_gnt  += int'(s_gnt[0]);
    end
    req = 1'b0;
    chk("b2b_done_pulses", 0, 32'(n_done), 32'd2);
    chk("b2b_grants", 0, 32'(n_gnt), 32'd2);
    tick();
    tick();

    // randomized traffic; DMA fields stay stable until the limit-4 arbiter reports done
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        1:       begin pr = 1'b1; pw = 1'b0; end
        2:       begin pr = 1'b0; pw = 1'b1; end
        default: begin pr = 1'b0; pw = 1'b0; end
      endcase
      pa  = 32'($urandom_range(0, 255));
      pwd = $urandom;
      pb  = 1'($urandom_range(0, 1));
      ph  = 1'($urandom_range(0, 1));
      if (!req && $urandom_range(0, 3) == 0) begin
        req = 1'b1;
        dw  = 1'($urandom_range(0, 1));
        db  = 1'($urandom_range(0, 1));
        dh  = 1'($urandom_range(0, 1));
        da  = 32'($urandom_range(0, 255));
        dwd = $urandom;
      end
      tick();
      if (s_done[0]) req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
